// File: rtl/gate_tester.sv
// Truth-table sweeper for a 2-input gate: drives each vector {dut_a,dut_b},
// waits SETTLE cycles, samples dut_c against EXPECT and accumulates mismatches.
module gate_tester #(
    parameter int         SETTLE = 2,
    parameter logic [3:0] EXPECT = 4'b1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_c,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Last value of the settle counter before moving on to SAMPLE.
    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] vec;
    logic [3:0] cnt;
    logic       mismatch;

    assign mismatch = (dut_c != EXPECT[vec]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (abort)            state_next = ST_IDLE;
                else if (SETTLE == 0) state_next = ST_SAMPLE;
                else                  state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)                     state_next = ST_IDLE;
                else if (cnt == SETTLE_LAST)   state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)            state_next = ST_IDLE;
                else if (vec == 2'd3) state_next = ST_DONE;
                else                  state_next = ST_DRIVE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vec       <= 2'd0;
            cnt       <= 4'd0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec       <= 2'd0;
                        err_count <= 3'd0;
                        fail_vec  <= 4'd0;
                        pass      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    cnt <= 4'd0;
                    if (abort) pass <= 1'b0;
                end
                ST_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (abort) pass <= 1'b0;
                end
                ST_SAMPLE: begin
                    // An abort on the sampling edge throws this vector's result away.
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            err_count     <= err_count + 3'd1;
                            fail_vec[vec] <= 1'b1;
                        end
                        if (vec == 2'd3) begin
                            pass <= (err_count == 3'd0) && !mismatch;
                        end else begin
                            vec <= vec + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign dut_a     = busy & vec[1];
    assign dut_b     = busy & vec[0];
    assign fsm_state = state;

endmodule

// File: doc/gate_tester.md
GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 The parameter SETTLE SHALL default to 2 and set the number of wait cycles between driving a vector and sampling the result, legal range 0..15.
REQ-002 The parameter EXPECT SHALL default to 4'b1000 and hold the expected result per vector, indexed by {dut_a,dut_b}; the default is a 2-input AND.
REQ-003 clock  in  1  sole clock; all state SHALL change on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request a full truth-table sweep; sampled only in IDLE.
REQ-006 abort  in  1  terminate the sweep in progress.
REQ-007 dut_c  in  1  result returned by the gate under test.
REQ-008 dut_a  out  1  stimulus bit, MSB of the vector index.
REQ-009 dut_b  out  1  stimulus bit, LSB of the vector index.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse when a sweep completes.
REQ-012 pass  out  1  high when the last completed sweep had zero mismatches.
REQ-013 err_count  out  3  number of mismatching vectors, 0..4.
REQ-014 fail_vec  out  4  bit i set when vector i mismatched.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE, SETTLE, SAMPLE and DONE, and SHALL hold a 2-bit vector register vec and a 4-bit settle counter.
REQ-016 In IDLE with start=1 at an edge, the block SHALL clear vec, err_count, fail_vec and pass, and enter DRIVE.
REQ-017 dut_a and dut_b SHALL equal vec[1] and vec[0] from registered state while busy, and SHALL be 0 otherwise.
REQ-018 DRIVE SHALL last one cycle, then go to SETTLE, or to SAMPLE directly when SETTLE=0.
REQ-019 SETTLE SHALL last exactly SETTLE cycles and then go to SAMPLE.
REQ-020 SAMPLE SHALL last one cycle; at its closing edge, if dut_c differs from EXPECT[vec], the block SHALL increment err_count and set fail_vec[vec].
REQ-021 After SAMPLE, the FSM SHALL go to DONE when vec=3; otherwise it SHALL increment vec and go to DRIVE.
REQ-022 The vector register SHALL not wrap during a sweep; exactly four vectors are applied, in the order 0,1,2,3.
REQ-023 Each vector SHALL occupy SETTLE+2 cycles, so done rises 4*(SETTLE+2) edges after the start-accept edge (16 for the default).
REQ-024 DONE SHALL last one cycle with done=1 and pass=(err_count==0), then return to IDLE.
REQ-025 pass, err_count and fail_vec SHALL hold their values in IDLE until the next start is accepted.
REQ-026 start while busy SHALL be ignored; start held high SHALL launch a new sweep on the first IDLE cycle after DONE.
REQ-027 abort=1 in DRIVE, SETTLE or SAMPLE SHALL move the FSM to IDLE at the next edge with no done pulse, pass=0, and the partial err_count/fail_vec retained; a SAMPLE comparison coinciding with abort SHALL be discarded.
REQ-028 abort SHALL have priority over start, and abort in IDLE or DONE SHALL have no effect.

Reset
REQ-029 While reset_n=0, the FSM SHALL be IDLE and all outputs, vec and the settle counter SHALL be 0, independent of clock.
REQ-030 Deassertion of reset_n SHALL be followed by normal operation from the first rising edge; reset mid-sweep SHALL discard all results.

Verification
REQ-031 Ideal AND on dut_c, SETTLE=2, start pulse -> vectors 00,01,10,11 each held 4 cycles, done at +16, pass=1, err_count=0, fail_vec=0000.
REQ-032 dut_c stuck at 1 -> done at +16, pass=0, err_count=3, fail_vec=0111.
REQ-033 SETTLE=0, ideal AND -> done at +8; start held high -> second sweep begins on the cycle after DONE.
REQ-034 abort during vector 2 SETTLE with dut_c stuck at 1 -> IDLE next edge, no done, pass=0, err_count=2, fail_vec=0011, dut_a=dut_b=0.
REQ-035 reset_n pulsed low mid-clock during SAMPLE -> outputs 0 immediately; start after release -> clean full sweep.
REQ-036 start pulsed during busy and during DONE -> ignored; exactly one done pulse per accepted start.
